// File: rtl/mac_dot_pkg.sv
// mac_dot_pkg: width helpers, accumulator saturation limits and the sideband type
// shared by mac_dot_pipe and its adder-tree stages.
package mac_dot_pkg;

    localparam int LIMIT_W = 64;

    // Control bits that ride through the pipeline alongside each beat.
    typedef struct packed {
        logic clr;
        logic en;
    } acc_ctrl_t;

    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Exact width of a LANES-term sum of DW x DW signed products.
    function automatic int sum_width(input int dw, input int lanes);
        return 2 * dw + clog2(lanes);
    endfunction

    function automatic logic signed [LIMIT_W-1:0] sat_max(input int acc_w);
        return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [LIMIT_W-1:0] sat_min(input int acc_w);
        return -(64'sd1 <<< (acc_w - 1));
    endfunction

endpackage

// File: rtl/mac_add_stage.sv
// mac_add_stage: one registered level of the pairwise adder tree. Each pair is
// sign-extended by one bit, so a level can never overflow.
module mac_add_stage #(
    parameter int IN_W = 16,
    parameter int N_IN = 2,
    parameter int SB_W = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic [SB_W-1:0]              in_sb,
    input  logic [N_IN*IN_W-1:0]         in_data,
    output logic                         out_valid,
    output logic [SB_W-1:0]              out_sb,
    output logic [(N_IN/2)*(IN_W+1)-1:0] out_data
);

    localparam int N_OUT = N_IN / 2;
    localparam int OUT_W = IN_W + 1;

    logic [N_OUT*OUT_W-1:0] sum_d;

    for (genvar j = 0; j < N_OUT; j++) begin : g_pair
        logic signed [IN_W-1:0] lhs;
        logic signed [IN_W-1:0] rhs;

        assign lhs = in_data[(2*j)*IN_W +: IN_W];
        assign rhs = in_data[(2*j+1)*IN_W +: IN_W];
        assign sum_d[j*OUT_W +: OUT_W] = OUT_W'(lhs) + OUT_W'(rhs);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sb    <= '0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_sb    <= in_sb;
            out_data  <= sum_d;
        end
    end

endmodule

// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: pipelined signed dot product of LANES operand pairs with a running accumulator.
// Define MAC_DOT_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module mac_dot_pipe
    import mac_dot_pkg::*;
#(
    parameter int DW    = 8,
    parameter int LANES = 2,
    parameter int ACC_W = 2 * DW + clog2(LANES) + 8
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LANES*DW-1:0]                    a_flat,
    input  logic [LANES*DW-1:0]                    b_flat,
    input  logic                                   acc_en,
    input  logic                                   acc_clr,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic signed [sum_width(DW, LANES)-1:0] s,
    output logic signed [ACC_W-1:0]                acc,
    output logic                                   acc_ovf
);

    localparam int SW = sum_width(DW, LANES);
    localparam int LV = clog2(LANES);
    localparam int PW = 2 * DW;
    localparam int CW = $bits(acc_ctrl_t);

    logic                    adv;
    logic [LANES*PW-1:0]     prod_d;
    logic [LANES*PW-1:0]     prod_q;
    logic                    prod_valid;
    acc_ctrl_t               prod_ctrl;
    logic signed [SW-1:0]    tree_sum;
    logic                    tree_valid;
    acc_ctrl_t               tree_ctrl;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_next;
    logic                    ovf_now;
    logic                    ovf_next;

    // Every stage moves in lockstep; a stalled output freezes the whole pipe.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [DW-1:0] a_k;
        logic signed [DW-1:0] b_k;
        logic signed [PW-1:0] a_x;
        logic signed [PW-1:0] b_x;

        assign a_k = a_flat[k*DW +: DW];
        assign b_k = b_flat[k*DW +: DW];
        assign a_x = PW'(a_k);
        assign b_x = PW'(b_k);
        assign prod_d[k*PW +: PW] = a_x * b_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_valid <= 1'b0;
            prod_ctrl  <= '0;
            prod_q     <= '0;
        end else if (adv) begin
            prod_valid <= in_valid;
            prod_ctrl  <= {acc_clr, acc_en};
            prod_q     <= prod_d;
        end
    end

    // Level l halves the term count and widens each term by one bit.
    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int IW = PW + l;
        localparam int NI = LANES >> l;

        logic [NI*IW-1:0]         lvl_in;
        logic                     lvl_in_valid;
        logic [CW-1:0]            lvl_in_ctrl;
        logic [(NI/2)*(IW+1)-1:0] lvl_out;
        logic                     lvl_out_valid;
        logic [CW-1:0]            lvl_out_ctrl;

        if (l == 0) begin : g_src
            assign lvl_in       = prod_q;
            assign lvl_in_valid = prod_valid;
            assign lvl_in_ctrl  = prod_ctrl;
        end else begin : g_src
            assign lvl_in       = g_lvl[l-1].lvl_out;
            assign lvl_in_valid = g_lvl[l-1].lvl_out_valid;
            assign lvl_in_ctrl  = g_lvl[l-1].lvl_out_ctrl;
        end

        mac_add_stage #(
            .IN_W (IW),
            .N_IN (NI),
            .SB_W (CW)
        ) u_add (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (adv),
            .in_valid  (lvl_in_valid),
            .in_sb     (lvl_in_ctrl),
            .in_data   (lvl_in),
            .out_valid (lvl_out_valid),
            .out_sb    (lvl_out_ctrl),
            .out_data  (lvl_out)
        );
    end

    assign tree_sum   = g_lvl[LV-1].lvl_out;
    assign tree_valid = g_lvl[LV-1].lvl_out_valid;
    assign tree_ctrl  = g_lvl[LV-1].lvl_out_ctrl;

    assign addend  = ACC_W'(tree_sum);
    assign acc_sum = acc + addend;
    assign ovf_now = (acc[ACC_W-1] == addend[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef MAC_DOT_SAT_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
`endif

    // A clear loads the beat's sum directly; it always fits because ACC_W >= SW.
    always_comb begin
        acc_next = acc;
        ovf_next = acc_ovf;
        if (tree_ctrl.clr) begin
            acc_next = addend;
            ovf_next = 1'b0;
        end else if (tree_ctrl.en) begin
            acc_next = acc_sum;
            if (ovf_now) begin
                ovf_next = 1'b1;
`ifdef MAC_DOT_SAT_EN
                acc_next = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
        end else if (adv) begin
            out_valid <= tree_valid;
            if (tree_valid) begin
                s       <= tree_sum;
                acc     <= acc_next;
                acc_ovf <= ovf_next;
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_pipe.sv
// tb_mac_dot_pipe: scoreboard bench for mac_dot_pipe; expected results come from a
// plain-arithmetic dot-product/accumulator model that follows MAC_DOT_SAT_EN like the RTL.
module tb_mac_dot_pipe;

    localparam int DW    = 8;
    localparam int LANES = 2;
    localparam int ACC_W = 18;
    localparam int SW    = 2 * DW + $clog2(LANES);
    localparam int AW    = LANES * DW;
    localparam longint ACC_MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MINV = -(longint'(1) <<< (ACC_W - 1));
    localparam longint ACC_SPAN = longint'(1) <<< ACC_W;

    typedef struct {
        longint s;
        longint acc;
        logic   ovf;
        int     accept_cycle;
        logic   chk_lat;
    } exp_t;

    exp_t exp_q[$];

    logic                    clk;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [AW-1:0]           a_flat;
    logic [AW-1:0]           b_flat;
    logic                    acc_en;
    logic                    acc_clr;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [SW-1:0]    s;
    logic signed [ACC_W-1:0] acc;
    logic                    acc_ovf;

    int     checks = 0;
    int     failures = 0;
    int     cycle = 0;
    longint model_acc = 0;
    logic   model_ovf = 1'b0;
    logic   lat_mode = 1'b0;
    logic   rand_done = 1'b0;
    logic   stall_prev = 1'b0;
    logic signed [63:0] held_s;
    logic signed [63:0] held_acc;

    mac_dot_pipe #(
        .DW    (DW),
        .LANES (LANES),
        .ACC_W (ACC_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .acc_en    (acc_en),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .acc       (acc),
        .acc_ovf   (acc_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic longint dotRef(input logic [AW-1:0] a, input logic [AW-1:0] b);
        longint total;
        logic signed [DW-1:0] x;
        logic signed [DW-1:0] y;
        total = 0;
        for (int k = 0; k < LANES; k++) begin
            x = a[k*DW +: DW];
            y = b[k*DW +: DW];
            total = total + longint'(x) * longint'(y);
        end
        return total;
    endfunction

    function automatic logic [AW-1:0] pack2(input int lane0, input int lane1);
        return {DW'(lane1), DW'(lane0)};
    endfunction

    // Reference model: runs on every accepted beat, in acceptance order.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_t   e;
            longint sum_v;
            longint next_v;
            sum_v = dotRef(a_flat, b_flat);
            if (acc_clr) begin
                model_acc = sum_v;
                model_ovf = 1'b0;
            end else if (acc_en) begin
                next_v = model_acc + sum_v;
                if (next_v > ACC_MAXV || next_v < ACC_MINV) begin
                    model_ovf = 1'b1;
`ifdef MAC_DOT_SAT_EN
                    next_v = (next_v > ACC_MAXV) ? ACC_MAXV : ACC_MINV;
`else
                    next_v = (next_v > ACC_MAXV) ? next_v - ACC_SPAN : next_v + ACC_SPAN;
`endif
                end
                model_acc = next_v;
            end
            e.s = sum_v;
            e.acc = model_acc;
            e.ovf = model_ovf;
            e.accept_cycle = cycle;
            e.chk_lat = lat_mode;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares each consumed output against the scoreboard and checks stall behaviour.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            checkOutput("in_ready", in_ready, !out_valid || out_ready);
            if (stall_prev) begin
                checkOutput("stall_out_valid", out_valid, 1);
                checkOutput("stall_s", s, held_s);
                checkOutput("stall_acc", acc, held_acc);
            end
            stall_prev = out_valid && !out_ready;
            held_s = s;
            held_acc = acc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output: got s=%0d acc=%0d, expected no output", s, acc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("s", s, e.s);
                    checkOutput("acc", acc, e.acc);
                    checkOutput("acc_ovf", acc_ovf, e.ovf);
                    if (e.chk_lat) checkOutput("latency", cycle - e.accept_cycle, 3);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Called and returns at 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                 input logic en, input logic clr);
        int   waited;
        logic taken;
        waited = 0;
        taken = 1'b0;
        in_valid = 1'b1;
        a_flat = a;
        b_flat = b;
        acc_en = en;
        acc_clr = clr;
        while (!taken && waited < 200) begin
            @(negedge clk);
            taken = in_ready;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!taken) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", waited);
        end
        in_valid = 1'b0;
        acc_en = 1'b0;
        acc_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_pending", exp_q.size(), 0);
    endtask

    task automatic randBeat();
        applyStimulus(AW'($urandom), AW'($urandom), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 9) == 0));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a_flat = '0;
        b_flat = '0;
        acc_en = 1'b0;
        acc_clr = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_s", s, 0);
        checkOutput("reset_acc", acc, 0);
        checkOutput("reset_acc_ovf", acc_ovf, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);
        idle(1);

        // Plain dot products, then the same beats accumulated.
        lat_mode = 1'b1;
        applyStimulus(pack2(5, 3), pack2(4, 2), 1'b0, 1'b0);
        applyStimulus(pack2(-9, 3), pack2(7, 4), 1'b0, 1'b0);
        applyStimulus(pack2(-16, 77), pack2(5, 6), 1'b0, 1'b0);
        applyStimulus(pack2(-13, -127), pack2(-5, 15), 1'b0, 1'b0);
        applyStimulus(pack2(5, 3), pack2(4, 2), 1'b0, 1'b1);
        applyStimulus(pack2(-9, 3), pack2(7, 4), 1'b1, 1'b0);
        applyStimulus(pack2(-16, 77), pack2(5, 6), 1'b1, 1'b0);
        applyStimulus(pack2(-13, -127), pack2(-5, 15), 1'b1, 1'b0);
        drain();

        // Extreme operands and accumulator overflow, then a clear.
        applyStimulus(pack2(-128, -128), pack2(-128, -128), 1'b0, 1'b1);
        repeat (4) applyStimulus(pack2(-128, -128), pack2(-128, -128), 1'b1, 1'b0);
        applyStimulus(pack2(3, -2), pack2(1, 1), 1'b0, 1'b1);
        drain();
        lat_mode = 1'b0;

        // Backpressure mid-stream.
        fork
            begin
                for (int i = 0; i < 10; i++) randBeat();
            end
            begin
                idle(4);
                out_ready = 1'b0;
                idle(5);
                out_ready = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure.
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    randBeat();
                    idle($urandom_range(0, 1) * $urandom_range(0, 2));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three beats in flight.
        out_ready = 1'b0;
        applyStimulus(pack2(7, -3), pack2(9, 11), 1'b0, 1'b1);
        applyStimulus(pack2(1, 2), pack2(3, 4), 1'b1, 1'b0);
        applyStimulus(pack2(-5, 6), pack2(7, 8), 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_acc", acc, 0);
        checkOutput("midreset_s", s, 0);
        checkOutput("midreset_acc_ovf", acc_ovf, 0);
        exp_q.delete();
        model_acc = 0;
        model_ovf = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(10);
        checkOutput("postreset_out_valid", out_valid, 0);
        applyStimulus(pack2(2, 3), pack2(4, 5), 1'b1, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
